// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - req/ack memory port between CPU and mem_responder (be lanes under MEM_BYTE_EN_EN)
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef MEM_BYTE_EN_EN
  logic [3:0]  be;
`endif
  logic        ack;
  logic [31:0] rdata;
  logic        err;

`ifdef MEM_BYTE_EN_EN
  modport master (output req, we, addr, wdata, be, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata, err);
`else
  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
`endif
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word memory responder with req/ack handshake and programmable wait states
// Optional byte-lane writes when MEM_BYTE_EN_EN is defined.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [31:0] data [2**DEPTH_LOG2];

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
`ifdef MEM_BYTE_EN_EN
  logic [3:0]  lat_be;
  logic [3:0]  cur_be;
`endif
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic                  align_ok;
  logic                  out_of_range;
  logic                  cur_err;
  logic                  enter_resp;

  // On the accepting edge the live inputs describe the request; afterwards the latched copies do.
  always_comb begin
    cur_we   = lat_we;
    cur_addr = lat_addr;
`ifdef MEM_BYTE_EN_EN
    cur_be   = lat_be;
`endif
    if (state == ST_IDLE) begin
      cur_we   = bus.we;
      cur_addr = bus.addr;
`ifdef MEM_BYTE_EN_EN
      cur_be   = bus.be;
`endif
    end
  end

  always_comb begin
    align_ok = (cur_addr[1:0] == 2'b00);
`ifdef MEM_BYTE_EN_EN
    // Sub-word writes may sit off word alignment as long as the address names the selected lane(s).
    if (cur_we) begin
      case (cur_be)
        4'b0001: align_ok = (cur_addr[1:0] == 2'd0);
        4'b0010: align_ok = (cur_addr[1:0] == 2'd1);
        4'b0100: align_ok = (cur_addr[1:0] == 2'd2);
        4'b1000: align_ok = (cur_addr[1:0] == 2'd3);
        4'b0011: align_ok = !cur_addr[1];
        4'b1100: align_ok = cur_addr[1];
        default: align_ok = (cur_addr[1:0] == 2'b00);
      endcase
    end
`endif
  end

  assign out_of_range = ((cur_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign cur_err      = !align_ok || out_of_range;
  assign cur_idx      = cur_addr[DEPTH_LOG2+1:2];
  assign lat_idx      = lat_addr[DEPTH_LOG2+1:2];

  assign enter_resp = ((state == ST_IDLE) && bus.req && (WAIT_INIT == 4'd0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
`ifdef MEM_BYTE_EN_EN
      lat_be    <= 4'd0;
`endif
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
`ifdef MEM_BYTE_EN_EN
            lat_be    <= bus.be;
`endif
            cnt       <= WAIT_INIT;
            state     <= (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Response registers are loaded on the edge into RESP so ack/rdata/err come straight from flops.
      ack_q   <= enter_resp;
      err_q   <= enter_resp && cur_err;
      rdata_q <= (enter_resp && !cur_we && !cur_err) ? data[cur_idx] : 32'd0;
    end
  end

  // Writes commit on the edge leaving RESP; a reset beforehand forces IDLE so nothing lands.
  always_ff @(posedge clk) begin
    if ((state == ST_RESP) && lat_we && !err_q) begin
`ifdef MEM_BYTE_EN_EN
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          data[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
`else
      data[lat_idx] <= lat_wdata;
`endif
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
endmodule
